keypad_decoder: RTL and testbench

KEYPAD_DECODER -- requirements
Module: keypad_decoder

---
 rtl/keypad_pkg.sv | 51 +++++
 rtl/keypad_decoder_if.sv | 25 ++
 rtl/keypad_keymap.sv | 13 +
 rtl/keypad_decoder.sv | 108 ++++++++++
 tb/tb_keypad_decoder.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared types and key decoding helpers for the 4x4 keypad decoder.
// total_val = {rows[3:0], columns[3:0]}; rows one-hot high, columns one-cold low.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  // Nibble (row*4 + col) holds the key code, row/col counted from 0 = row 1/column 1.
  // Rows: 1,2,3,A / 4,5,6,B / 7,8,9,C / E,0,F,D.
  localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

  function automatic logic is_legal(input logic [7:0] tv);
    logic [3:0] cols_low;
    cols_low = ~tv[3:0];
    return ($countones(tv[7:4]) == 1) && ($countones(cols_low) == 1);
  endfunction

  function automatic logic [1:0] row_index(input logic [3:0] rows);
    logic [1:0] r;
    case (rows)
      4'b1000: r = 2'd0;
      4'b0100: r = 2'd1;
      4'b0010: r = 2'd2;
      default: r = 2'd3;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] col_index(input logic [3:0] cols);
    logic [1:0] c;
    case (cols)
      4'b0111: c = 2'd0;
      4'b1011: c = 2'd1;
      4'b1101: c = 2'd2;
      default: c = 2'd3;
    endcase
    return c;
  endfunction

  // Only meaningful when is_legal(tv) holds.
  function automatic logic [3:0] key_lookup(input logic [7:0] tv);
    logic [3:0] idx;
    idx = {row_index(tv[7:4]), col_index(tv[3:0])};
    return KEY_MAP[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/keypad_decoder_if.sv
// Bus between the row scanner and the keypad decoder, plus the FSM state for observation.
interface keypad_decoder_if;
  import keypad_pkg::*;

  // enable is a one-cycle strobe with no ready: the decoder samples it every cycle but
  // acts on it only in IDLE; key_valid is a one-cycle pulse with key_code held after it.
  logic       enable;
  logic [7:0] total_val;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] digit_new;
  logic [3:0] digit_old;
  logic       held;
  state_t     state;

  modport master (
    output enable, total_val,
    input  key_valid, key_code, digit_new, digit_old, held, state
  );

  modport slave (
    input  enable, total_val,
    output key_valid, key_code, digit_new, digit_old, held, state
  );
endinterface

// File: rtl/keypad_keymap.sv
// Combinational decode of a raw {rows, columns} code into {legal, key code}.
module keypad_keymap
  import keypad_pkg::*;
(
  input  logic [7:0] total_val,
  output logic       legal,
  output logic [3:0] code
);

  assign legal = is_legal(total_val);
  assign code  = key_lookup(total_val);

endmodule

// File: rtl/keypad_decoder.sv
// Debounced keypad decoder: one key_valid pulse per accepted press, with two-digit history.
// Press and release both need DEBOUNCE_CYCLES stable cycles before the FSM commits.
module keypad_decoder
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic          clk,
  input  logic          reset,
  keypad_decoder_if.slave bus
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       captured_q;
  logic             key_valid_q;
  logic [3:0]       key_code_q;
  logic [3:0]       digit_new_q;
  logic [3:0]       digit_old_q;
  logic             held_q;

  logic             map_legal;
  logic [3:0]       map_code;
  logic             same_code;

  keypad_keymap u_keymap (
    .total_val (bus.total_val),
    .legal     (map_legal),
    .code      (map_code)
  );

  assign same_code = (bus.total_val == captured_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      captured_q  <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      digit_new_q <= '0;
      digit_old_q <= '0;
      held_q      <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.enable && map_legal) begin
            captured_q <= bus.total_val;
            cnt_q      <= '0;
            state_q    <= ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (!same_code) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else if (cnt_q == CNT_MAX) begin
            // total_val equals captured here, so map_code is the captured key.
            cnt_q       <= '0;
            state_q     <= ST_HELD;
            held_q      <= 1'b1;
            key_valid_q <= 1'b1;
            key_code_q  <= map_code;
            digit_old_q <= digit_new_q;
            digit_new_q <= map_code;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_HELD: begin
          if (!same_code) begin
            cnt_q   <= '0;
            state_q <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (same_code) begin
            cnt_q   <= '0;
            state_q <= ST_HELD;
          end else if (cnt_q == CNT_MAX) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
            held_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= ST_IDLE;
          held_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.key_valid = key_valid_q;
  assign bus.key_code  = key_code_q;
  assign bus.digit_new = digit_new_q;
  assign bus.digit_old = digit_old_q;
  assign bus.held      = held_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_keypad_decoder.sv
// Self-checking bench for keypad_decoder with DEBOUNCE_CYCLES=4; accepted keys go through a scoreboard queue.
module tb_keypad_decoder;
  import keypad_pkg::*;

  localparam int DEB = 4;
  localparam logic [7:0] NO_KEY = 8'h0F;

  logic clk;
  logic reset;
  keypad_decoder_if bus ();

  keypad_decoder #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [3:0] exp_q[$];
  int         checks;
  int         errors;
  int         cyc;
  int         cap_cyc;
  int         pulse_cnt;
  logic [3:0] key_tab [4][4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Independent reference: rows[3] is row 1, columns[3] is column 1 (active low).
  function automatic logic [3:0] model_code(input logic [7:0] tv);
    int r;
    int c;
    r = 0;
    c = 0;
    for (int i = 0; i < 4; i++) begin
      if (tv[4+i]) r = 3 - i;
      if (!tv[i]) c = 3 - i;
    end
    return key_tab[r][c];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [7:0] code, input int hold);
    bus.enable    = 1'b1;
    bus.total_val = code;
    tick(1);
    cap_cyc       = cyc;
    bus.enable    = 1'b0;
    tick(hold);
  endtask

  task automatic release_key(input int n);
    bus.total_val = NO_KEY;
    tick(n);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_key_valid"}, 32'(bus.key_valid), 32'd0);
    check({tag, "_key_code"},  32'(bus.key_code),  32'd0);
    check({tag, "_digit_new"}, 32'(bus.digit_new), 32'd0);
    check({tag, "_digit_old"}, 32'(bus.digit_old), 32'd0);
    check({tag, "_held"},      32'(bus.held),      32'd0);
    check({tag, "_state"},     32'(bus.state),     32'(ST_IDLE));
  endtask

  // ---------------- output monitor ----------------
  always @(posedge clk) begin
    cyc++;
    #1;
    if (bus.key_valid) begin
      pulse_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        check("pulse_key_code",  32'(bus.key_code),  32'(e));
        check("pulse_digit_new", 32'(bus.digit_new), 32'(e));
        check("pulse_latency",   32'(cyc - cap_cyc), 32'(DEB));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int pulses_before;
    key_tab = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                '{4'h4, 4'h5, 4'h6, 4'hB},
                '{4'h7, 4'h8, 4'h9, 4'hC},
                '{4'hE, 4'h0, 4'hF, 4'hD}};
    checks = 0; errors = 0; cyc = 0; cap_cyc = 0; pulse_cnt = 0;
    reset = 1'b0;
    bus.enable = 1'b0;
    bus.total_val = NO_KEY;
    tick(3);
    check_outputs_zero("reset");
    reset = 1'b1;
    tick(2);

    // Clean press of key 1
    exp_q.push_back(model_code(8'b1000_0111));
    press(8'b1000_0111, 9);
    check("clean_held", 32'(bus.held), 32'd1);
    check("clean_pulses", 32'(pulse_cnt), 32'd1);
    release_key(DEB + 2);
    check("clean_rel_state", 32'(bus.state), 32'(ST_IDLE));
    check("clean_rel_held", 32'(bus.held), 32'd0);
    check("clean_key_code", 32'(bus.key_code), 32'h1);

    // Bounce during debounce
    pulses_before = pulse_cnt;
    press(8'b0100_1011, 2);
    bus.total_val = 8'b0100_1111;
    tick(2);
    check("bounce_state", 32'(bus.state), 32'(ST_IDLE));
    tick(DEB);
    check("bounce_pulses", 32'(pulse_cnt), 32'(pulses_before));
    release_key(2);

    // Two-digit history
    exp_q.push_back(model_code(8'b0010_1101));
    press(8'b0010_1101, 8);
    release_key(DEB + 2);
    exp_q.push_back(model_code(8'b0001_1011));
    press(8'b0001_1011, 8);
    check("hist_digit_old", 32'(bus.digit_old), 32'(model_code(8'b0010_1101)));
    check("hist_digit_new", 32'(bus.digit_new), 32'h0);
    check("hist_key_code",  32'(bus.key_code),  32'h0);
    release_key(DEB + 2);

    // Release bounce while key D held, plus an ignored enable in HELD
    exp_q.push_back(model_code(8'b0001_1110));
    press(8'b0001_1110, 8);
    pulses_before = pulse_cnt;
    bus.total_val = NO_KEY;
    tick(1);
    check("relb_state_release", 32'(bus.state), 32'(ST_RELEASE));
    tick(1);
    bus.total_val = 8'b0001_1110;
    tick(1);
    check("relb_state_held", 32'(bus.state), 32'(ST_HELD));
    check("relb_held", 32'(bus.held), 32'd1);
    bus.enable = 1'b1;
    tick(1);
    bus.enable = 1'b0;
    tick(8);
    check("relb_pulses", 32'(pulse_cnt), 32'(pulses_before));
    check("relb_key_code", 32'(bus.key_code), 32'hD);
    release_key(DEB + 2);

    // Illegal code never starts a press
    pulses_before = pulse_cnt;
    bus.enable = 1'b1;
    bus.total_val = 8'b1000_0011;
    tick(1);
    bus.enable = 1'b0;
    check("illegal_state", 32'(bus.state), 32'(ST_IDLE));
    tick(DEB + 3);
    check("illegal_pulses", 32'(pulse_cnt), 32'(pulses_before));
    release_key(2);

    // Asynchronous reset one cycle into debounce
    pulses_before = pulse_cnt;
    press(8'b1000_0111, 1);
    check("prereset_state", 32'(bus.state), 32'(ST_DEBOUNCE));
    #2;
    reset = 1'b0;
    #1;
    check_outputs_zero("midreset");
    tick(2);
    #2;
    reset = 1'b1;
    tick(DEB + 6);
    check("postreset_state", 32'(bus.state), 32'(ST_IDLE));
    check("postreset_pulses", 32'(pulse_cnt), 32'(pulses_before));
    release_key(2);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("total_pulses", 32'(pulse_cnt), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
